// File: rtl/obi_rr_arbiter_pkg.sv
// Shared OBI channel types, config and helpers for the round-robin arbiter.
// Holds default A/R/req/rsp structs, the config struct and idx_width().
package obi_rr_arbiter_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned IdWidth   = 1;

  typedef struct packed {
    logic UseRReady;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{UseRReady: 1'b0};

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth/8-1:0] be;
    logic [DataWidth-1:0]   wdata;
    logic [IdWidth-1:0]     aid;
  } obi_a_chan_def_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic [IdWidth-1:0]   rid;
    logic                 err;
  } obi_r_chan_def_t;

  typedef struct packed {
    logic            req;
    obi_a_chan_def_t a;
    logic            rready;
  } obi_req_def_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    obi_r_chan_def_t r;
  } obi_rsp_def_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obi_rr_arbiter_idx.sv
// Index FIFO for obi_rr_arbiter: records the issuing port of each transaction.
// Ports: push_i/pop_i, data_i, head_o, full_o, empty_o, count_o; async high rst_i.
module obi_rr_idx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, wr_d;
  logic [PtrW-1:0]  rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = (wr_q == LastPtr) ? '0 : wr_q + PtrW'(1);
    if (do_pop)  rd_d = (rd_q == LastPtr) ? '0 : rd_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while counted.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/obi_rr_arbiter.sv
// Round-robin OBI arbiter: N requesters share one manager port, R routed by FIFO.
// Ports: clk_i, rst_i, sbr_ports_req_i/rsp_o[N], mgr_port_req_o/rsp_i, busy_o.
module obi_rr_arbiter
  import obi_rr_arbiter_pkg::*;
#(
  parameter obi_cfg_t    ObiCfg       = ObiDefaultConfig,
  parameter type         obi_a_chan_t = obi_a_chan_def_t,
  parameter type         obi_r_chan_t = obi_r_chan_def_t,
  parameter type         obi_req_t    = obi_req_def_t,
  parameter type         obi_rsp_t    = obi_rsp_def_t,
  parameter int unsigned NumSbrPorts  = 4,
  parameter int unsigned MaxTrans     = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  obi_req_t sbr_ports_req_i [NumSbrPorts],
  output obi_rsp_t sbr_ports_rsp_o [NumSbrPorts],
  output obi_req_t mgr_port_req_o,
  input  obi_rsp_t mgr_port_rsp_i,
  output logic     busy_o
);

  localparam int unsigned IdxW = idx_width(NumSbrPorts);
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  typedef logic [IdxW-1:0] idx_t;

  idx_t            rr_q, lock_idx_q;
  logic            lock_q;
  idx_t            sel, head, sel_nxt;
  logic            found;
  int unsigned     cand;
  logic            full, empty, fifo_full;
  logic [CntW-1:0] count;
  logic            mgr_req, hs, pop, rready;
  obi_a_chan_t     mgr_a;
  obi_r_chan_t     mgr_r;

  // Lock holds the selection while a request waits for gnt.
  always_comb begin
    sel   = rr_q;
    found = 1'b0;
    cand  = 0;
    if (lock_q) begin
      sel = lock_idx_q;
    end else begin
      for (int unsigned i = 0; i < NumSbrPorts; i++) begin
        cand = 32'(rr_q) + i;
        if (cand >= NumSbrPorts) cand = cand - NumSbrPorts;
        if (!found && sbr_ports_req_i[cand].req) begin
          sel   = idx_t'(cand);
          found = 1'b1;
        end
      end
    end
  end

  assign full    = (count == CntW'(MaxTrans));
  assign mgr_req = sbr_ports_req_i[sel].req & ~full;
  assign mgr_a   = sbr_ports_req_i[sel].a;
  assign hs      = mgr_req & mgr_port_rsp_i.gnt;
  assign sel_nxt = (sel == idx_t'(NumSbrPorts - 1)) ? '0 : sel + idx_t'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (hs) begin
      rr_q   <= sel_nxt;
      lock_q <= 1'b0;
    end else if (mgr_req) begin
      lock_q     <= 1'b1;
      lock_idx_q <= sel;
    end
  end

  assign rready = ObiCfg.UseRReady ? (sbr_ports_req_i[head].rready & ~empty) : 1'b1;
  assign pop    = mgr_port_rsp_i.rvalid & rready & ~empty;
  assign mgr_r  = mgr_port_rsp_i.r;
  assign busy_o = ~empty;

  obi_rr_idx_fifo #(
    .Depth (MaxTrans),
    .Width (IdxW),
    .CntW  (CntW)
  ) i_idx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (hs),
    .pop_i   (pop),
    .data_i  (sel),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    mgr_port_req_o        = '0;
    mgr_port_req_o.req    = mgr_req;
    mgr_port_req_o.a      = mgr_a;
    mgr_port_req_o.rready = rready;
  end

  always_comb begin
    for (int unsigned i = 0; i < NumSbrPorts; i++) begin
      sbr_ports_rsp_o[i]        = '0;
      sbr_ports_rsp_o[i].gnt    = (idx_t'(i) == sel) & mgr_port_rsp_i.gnt & ~full;
      sbr_ports_rsp_o[i].rvalid = (idx_t'(i) == head) & mgr_port_rsp_i.rvalid & ~empty;
      sbr_ports_rsp_o[i].r      = mgr_r;
    end
  end

  a_rvalid_empty: assert property (
    @(posedge clk_i) disable iff (rst_i) !(mgr_port_rsp_i.rvalid && empty));

  a_full_match: assert property (
    @(posedge clk_i) disable iff (rst_i) fifo_full == full);

endmodule
